// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder
// LCD-module end of an 8-bit HD44780 bus (lcd_rs, lcd_rw, lcd_e, lcd_d).
// It decodes instruction and data writes, keeps an 80-byte DDRAM and an
// address counter, and answers reads with {BF, AC} or DDRAM[AC]. It serves as
// the loopback target and bench responder for the LCD driver firmware.
//
// Optional build macro: LCD_RESP_VIOLATION_EN
//   When defined, protocol_err is a sticky flag. It sets on any transaction
//   ignored while busy, and on any RS/RW/D change while synchronized E is high.
//   When undefined, protocol_err is tied low and the checker is not built.
module lcd_hd44780_responder #(
    parameter int CMD_CYCLES   = 1000,
    parameter int CLEAR_CYCLES = 41000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_d_in,
    output logic [7:0] lcd_d_out,
    output logic       lcd_d_oe,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    output logic       busy,
    output logic [6:0] addr_counter,
    output logic       protocol_err
);

    localparam int MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [6:0] LAST_ADDR = 7'd79;
    localparam logic [6:0] LINE_SPAN = 7'd80;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] d;
    } bus_t;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    bus_t             bus_raw;
    bus_t             bus_meta;
    bus_t             bus_sync;
    bus_t             bus_prev;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] load_cycles;
    logic [6:0]       ac;
    logic [6:0]       ac_next;
    logic [6:0]       ac_stepped;
    logic             inc_mode;
    logic             inc_mode_next;
    logic [7:0]       ddram [80];
    logic             e_fall;
    logic             is_data_read;
    logic             accept_write;
    logic             accept_read;

    assign bus_raw      = {lcd_e, lcd_rs, lcd_rw, lcd_d_in};
    assign addr_counter = ac;

    // All bus lines share one synchronizer so RS/RW/D stay aligned with E;
    // bus_prev is one more stage of history for the E falling-edge detect.
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge value of its source, exactly like the flops it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_meta <= '0;
            bus_sync <= '0;
            bus_prev <= '0;
        end else begin
            bus_meta <= bus_raw;
            bus_sync <= bus_meta;
            bus_prev <= bus_sync;
        end
    end

    // A transaction commits on the synchronized E fall, using the bus values
    // captured while E was still high. Status reads (RS=0) never commit state.
    assign e_fall       = bus_prev.e & ~bus_sync.e;
    assign is_data_read = bus_prev.rw & bus_prev.rs;
    assign accept_write = e_fall & ~bus_prev.rw & ~busy;
    assign accept_read  = e_fall & is_data_read & ~busy;

    // Address counter step in the current entry direction, wrapping at 0x4F.
    always_comb begin
        if (inc_mode) begin
            ac_stepped = (ac == LAST_ADDR) ? 7'd0 : ac + 7'd1;
        end else begin
            ac_stepped = (ac == 7'd0) ? LAST_ADDR : ac - 7'd1;
        end
    end

    // Decode of the committed transaction; instructions by highest set bit.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        ac_next       = ac;
        inc_mode_next = inc_mode;
        load_cycles   = CNT_W'(CMD_CYCLES);
        if (bus_prev.rs) begin
            ac_next = ac_stepped;
        end else if (bus_prev.d[7]) begin
            ac_next = (bus_prev.d[6:0] >= LINE_SPAN) ? bus_prev.d[6:0] - LINE_SPAN
                                                     : bus_prev.d[6:0];
        end else if (bus_prev.d[6:3] != 4'd0) begin
            ac_next = ac;
        end else if (bus_prev.d[2]) begin
            inc_mode_next = bus_prev.d[1];
        end else if (bus_prev.d[1]) begin
            ac_next     = 7'd0;
            load_cycles = CNT_W'(CLEAR_CYCLES);
        end else if (bus_prev.d[0]) begin
            ac_next       = 7'd0;
            inc_mode_next = 1'b1;
            load_cycles   = CNT_W'(CLEAR_CYCLES);
        end
    end

    // Busy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Busy next-state: an accepted write starts a busy window that ends after
    // the cycle in which the counter reads 1.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_write) state_next = BUSY;
            BUSY: if (busy_cnt == CNT_W'(1)) state_next = IDLE;
        endcase
    end

    // Busy flag decoded from the state register.
    always_comb begin
        busy = (state == BUSY);
    end

    // Busy duration counter: loaded on an accepted write, counts down while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (accept_write) begin
            busy_cnt <= load_cycles;
        end else if (state == BUSY) begin
            busy_cnt <= busy_cnt - CNT_W'(1);
        end
    end

    // Address counter and entry direction update on accepted writes and data reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac       <= 7'd0;
            inc_mode <= 1'b1;
        end else if (accept_write || accept_read) begin
            ac       <= ac_next;
            inc_mode <= inc_mode_next;
        end
    end

    // DDRAM write port for accepted data writes.
    // NOTE: the display RAM is deliberately left out of reset; contents survive
    // a reset just as on the real module, and the array can map onto RAM.
    always_ff @(posedge clk) begin
        if (accept_write && bus_prev.rs) begin
            ddram[ac] <= bus_prev.d;
        end
    end

    // Accepted-write report, one pulse per write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_rs    <= 1'b0;
            cmd_data  <= 8'h00;
        end else begin
            cmd_valid <= accept_write;
            if (accept_write) begin
                cmd_rs   <= bus_prev.rs;
                cmd_data <= bus_prev.d;
            end
        end
    end

    // Read-back path, registered every cycle; enabled while E and RW are high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_d_out <= 8'h00;
            lcd_d_oe  <= 1'b0;
        end else begin
            lcd_d_out <= bus_sync.rs ? ddram[ac] : {busy, ac};
            lcd_d_oe  <= bus_sync.e & bus_sync.rw;
        end
    end

`ifdef LCD_RESP_VIOLATION_EN
    logic ignored_txn;
    logic bus_moved;

    assign ignored_txn = e_fall & (~bus_prev.rw | bus_prev.rs) & busy;
    assign bus_moved   = bus_sync.e & bus_prev.e &
                         ({bus_sync.rs, bus_sync.rw, bus_sync.d} !=
                          {bus_prev.rs, bus_prev.rw, bus_prev.d});

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protocol_err <= 1'b0;
        end else if (ignored_txn || bus_moved) begin
            protocol_err <= 1'b1;
        end
    end
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder
// Directed bench for lcd_hd44780_responder. A transaction-level model tracks
// AC, entry direction, DDRAM and remaining busy time from the raw bus, and a
// compare process checks the DUT against it on every falling clock edge.
// Literal expectations from the test plan pin the model itself.
`timescale 1ns/1ps
module tb_lcd_hd44780_responder;

    localparam int CMD_N = 1000;
    localparam int CLR_N = 41000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e = 1'b0;
    logic [7:0] lcd_d_in = 8'h00;
    logic [7:0] lcd_d_out;
    logic       lcd_d_oe;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       busy;
    logic [6:0] addr_counter;
    logic       protocol_err;

    lcd_hd44780_responder #(
        .CMD_CYCLES  (CMD_N),
        .CLEAR_CYCLES(CLR_N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_d_in    (lcd_d_in),
        .lcd_d_out   (lcd_d_out),
        .lcd_d_oe    (lcd_d_oe),
        .cmd_valid   (cmd_valid),
        .cmd_rs      (cmd_rs),
        .cmd_data    (cmd_data),
        .busy        (busy),
        .addr_counter(addr_counter),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

`ifdef LCD_RESP_VIOLATION_EN
    localparam bit VIOL_EN = 1'b1;
`else
    localparam bit VIOL_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] d;
    } smp_t;

    typedef struct {
        smp_t       h [4];       // raw bus samples, h[0] newest
        int         ac;
        bit         inc;
        int         busy_left;
        bit         perr;
        bit         cmd_valid;
        bit         cmd_rs;
        logic [7:0] cmd_data;
        bit         oe;
        logic [7:0] dout;
        bit         dout_known;
        bit         wr;
        int         waddr;
        logic [7:0] wdata;
    } model_t;

    model_t     model;
    model_t     nxt;
    logic [7:0] m_mem [80];
    bit         m_mem_ok [80];

    function automatic model_t reset_model();
        model_t r;
        for (int i = 0; i < 4; i++) r.h[i] = '0;
        r.ac = 0; r.inc = 1'b1; r.busy_left = 0; r.perr = 1'b0;
        r.cmd_valid = 1'b0; r.cmd_rs = 1'b0; r.cmd_data = 8'h00;
        r.oe = 1'b0; r.dout = 8'h00; r.dout_known = 1'b1;
        r.wr = 1'b0; r.waddr = 0; r.wdata = 8'h00;
        return r;
    endfunction

    function automatic int step_ac(input int ac, input bit inc);
        return inc ? (ac + 1) % 80 : (ac + 79) % 80;
    endfunction

    // One clock of the model. Commit lands on the third edge after the raw
    // E fall and uses the last bus sample taken while E was high.
    function automatic model_t step(input model_t m, input smp_t s,
                                    input logic [7:0] mem_at_ac, input bit mem_ok_at_ac);
        model_t n;
        smp_t   t;
        bit     was_busy;
        n = m;
        was_busy = (m.busy_left > 0);
        n.h[3] = m.h[2]; n.h[2] = m.h[1]; n.h[1] = m.h[0]; n.h[0] = s;
        n.oe = n.h[2].e & n.h[2].rw;
        if (n.h[2].rs) begin
            n.dout = mem_at_ac; n.dout_known = mem_ok_at_ac;
        end else begin
            n.dout = {was_busy, 7'(m.ac)}; n.dout_known = 1'b1;
        end
        n.wr = 1'b0;
        n.cmd_valid = 1'b0;
        if (was_busy) n.busy_left = m.busy_left - 1;
        t = n.h[3];
        if (t.e && !n.h[2].e && !(t.rw && !t.rs)) begin
            if (was_busy) begin
                if (VIOL_EN) n.perr = 1'b1;
            end else if (t.rw) begin
                n.ac = step_ac(m.ac, m.inc);
            end else begin
                n.cmd_valid = 1'b1; n.cmd_rs = t.rs; n.cmd_data = t.d;
                n.busy_left = CMD_N;
                if (t.rs) begin
                    n.wr = 1'b1; n.waddr = m.ac; n.wdata = t.d;
                    n.ac = step_ac(m.ac, m.inc);
                end else if (t.d == 8'h01) begin
                    n.ac = 0; n.inc = 1'b1; n.busy_left = CLR_N;
                end else if (t.d == 8'h02 || t.d == 8'h03) begin
                    n.ac = 0; n.busy_left = CLR_N;
                end else if (t.d >= 8'h04 && t.d <= 8'h07) begin
                    n.inc = t.d[1];
                end else if (t.d >= 8'h80) begin
                    n.ac = int'(t.d[6:0]) % 80;
                end
            end
        end
        return n;
    endfunction

    always_comb nxt = step(model, smp_t'({lcd_e, lcd_rs, lcd_rw, lcd_d_in}),
                           m_mem[model.ac], m_mem_ok[model.ac]);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model <= reset_model();
        end else begin
            model <= nxt;
            if (nxt.wr) begin
                m_mem[nxt.waddr]    <= nxt.wdata;
                m_mem_ok[nxt.waddr] <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         run_checks = 1'b0;
    int         run_len = 0;
    int         last_busy_len = 0;
    int         n_cmd = 0;
    logic [7:0] last_cmd_data = 8'h00;
    logic       last_cmd_rs = 1'b0;

    always @(negedge clk) begin
        if (run_checks) begin
            check("busy", 32'(busy), 32'(model.busy_left > 0));
            check("addr_counter", 32'(addr_counter), 32'(model.ac));
            check("cmd_valid", 32'(cmd_valid), 32'(model.cmd_valid));
            if (model.cmd_valid) begin
                check("cmd_rs", 32'(cmd_rs), 32'(model.cmd_rs));
                check("cmd_data", 32'(cmd_data), 32'(model.cmd_data));
            end
            check("lcd_d_oe", 32'(lcd_d_oe), 32'(model.oe));
            if (model.oe && model.dout_known)
                check("lcd_d_out", 32'(lcd_d_out), 32'(model.dout));
            check("protocol_err", 32'(protocol_err), 32'(model.perr));
        end
        run_len <= busy ? run_len + 1 : 0;
        if (!busy && run_len > 0) last_busy_len <= run_len;
        if (cmd_valid) begin
            n_cmd         <= n_cmd + 1;
            last_cmd_data <= cmd_data;
            last_cmd_rs   <= cmd_rs;
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_txn(input bit rs, input bit rw, input logic [7:0] d,
                           output logic [7:0] rdata);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_d_in = d;
        @(negedge clk);
        lcd_e = 1'b1;
        repeat (5) @(negedge clk);
        rdata = lcd_d_out;
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wr(input bit rs, input logic [7:0] d);
        logic [7:0] unused_rd;
        bus_txn(rs, 1'b0, d, unused_rd);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        int         cmd_before;

        #1 reset = 1'b1;
        run_checks = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state, then a status read returns BF=0, AC=0.
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ac", 32'(addr_counter), 32'd0);
        bus_txn(1'b0, 1'b1, 8'h00, rd);
        check("status_after_reset", 32'(rd), 32'h00);

        // Set DDRAM address 0x05; status read while busy shows BF=1.
        wr(1'b0, 8'h85);
        check("cmd_0x85_data", 32'(last_cmd_data), 32'h85);
        check("cmd_0x85_rs", 32'(last_cmd_rs), 32'd0);
        bus_txn(1'b0, 1'b1, 8'h00, rd);
        check("status_while_busy", 32'(rd), 32'h85);
        wait_idle();
        check("busy_len_cmd", 32'(last_busy_len), 32'(CMD_N));
        check("ac_after_0x85", 32'(addr_counter), 32'h05);

        // Address wrap on set: 0x55 maps to 0x05 -> use 0x56 -> 0x06.
        wr(1'b0, 8'hD6);
        wait_idle();
        check("ac_set_wrap", 32'(addr_counter), 32'h06);

        // Data write at 0x4F wraps AC to 0, then read it back.
        wr(1'b0, 8'hCF);
        wait_idle();
        wr(1'b1, 8'h41);
        check("cmd_data_rs", 32'(last_cmd_rs), 32'd1);
        wait_idle();
        check("ac_inc_wrap", 32'(addr_counter), 32'h00);
        wr(1'b0, 8'hCF);
        wait_idle();
        bus_txn(1'b1, 1'b1, 8'h00, rd);
        check("read_ddram_4f", 32'(rd), 32'h41);
        check("ac_after_read", 32'(addr_counter), 32'h00);
        check("read_sets_no_busy", 32'(busy), 32'd0);

        // Decrement mode; 0x0E has bit 3 highest and must not alter I/D.
        wr(1'b0, 8'h04);
        wait_idle();
        wr(1'b0, 8'h0E);
        wait_idle();
        wr(1'b0, 8'h80);
        wait_idle();
        wr(1'b1, 8'h5A);
        wait_idle();
        check("ac_dec_wrap", 32'(addr_counter), 32'h4F);
        wr(1'b0, 8'h80);
        wait_idle();
        bus_txn(1'b1, 1'b1, 8'h00, rd);
        check("read_ddram_00", 32'(rd), 32'h5A);
        check("ac_after_dec_read", 32'(addr_counter), 32'h4F);

        // Clear, then a write ~500 cycles into the busy window is ignored.
        wr(1'b0, 8'h01);
        check("ac_after_clear", 32'(addr_counter), 32'h00);
        cmd_before = n_cmd;
        repeat (490) @(negedge clk);
        wr(1'b0, 8'h33);
        check("ignored_no_cmd", 32'(n_cmd - cmd_before), 32'd0);
        check("ignored_last_cmd", 32'(last_cmd_data), 32'h01);
        check("perr_after_ignore", 32'(protocol_err), 32'(VIOL_EN));
        wait_idle();
        check("busy_len_clear", 32'(last_busy_len), 32'(CLR_N));
        check("ac_after_clear_idle", 32'(addr_counter), 32'h00);
        wr(1'b1, 8'h11);
        wait_idle();
        check("clear_sets_inc", 32'(addr_counter), 32'h01);

        // Return Home (0x03) while AC is nonzero; reset during its long busy.
        wr(1'b0, 8'h03);
        check("ac_after_home", 32'(addr_counter), 32'h00);
        repeat (1500) @(negedge clk);
        check("home_still_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_home_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset 10 cycles into a CMD busy window clears everything at once.
        wr(1'b0, 8'hA3);
        wait_idle();
        wr(1'b1, 8'h77);
        repeat (10) @(negedge clk);
        check("pre_reset_ac", 32'(addr_counter), 32'h24);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_ac", 32'(addr_counter), 32'd0);
        check("async_reset_perr", 32'(protocol_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Synthesizable, cycle-accurate model of the LCD-module end of the 8-bit HD44780 bus that our PicoBlaze LCD port logic drives (lcd_rs, lcd_rw, lcd_e, lcd_d).
- Decodes instruction and data writes, keeps an 80-byte DDRAM and an address counter, and returns busy flag, address or DDRAM data on reads.
- Used as the on-chip loopback target and bench responder for LCD driver firmware.

Parameters:
- CMD_CYCLES, 1000, busy duration in clk cycles after a normal instruction or data write (40 us at 25 MHz).
- CLEAR_CYCLES, 41000, busy duration in clk cycles after Clear Display or Return Home (1.64 ms at 25 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- lcd_rs  input  1  register select: 0 instruction/status, 1 data.
- lcd_rw  input  1  1 read, 0 write.
- lcd_e  input  1  enable strobe; a transaction commits on its falling edge.
- lcd_d_in  input  8  bus data from the initiator.
- lcd_d_out  output  8  bus data returned on reads.
- lcd_d_oe  output  1  responder drives the bus.
- cmd_valid  output  1  one-cycle pulse per accepted write.
- cmd_rs  output  1  RS of the accepted write; valid with cmd_valid.
- cmd_data  output  8  data of the accepted write; valid with cmd_valid.
- busy  output  1  busy flag (BF).
- addr_counter  output  7  address counter (AC).
- protocol_err  output  1  sticky violation flag (see Optional Feature).

Behaviour:
- Reset (async): AC=0, I/D=1 (increment), busy=0, state IDLE, busy counter=0, cmd_valid=0, cmd_rs=0, cmd_data=0, lcd_d_out=0, lcd_d_oe=0, protocol_err=0. DDRAM is not reset.
- Input capture: lcd_rs, lcd_rw, lcd_e and lcd_d_in all pass through the same 2-FF synchronizer. A falling edge of synchronized E commits the transaction using the synchronized RS/RW/D from the cycle before the fall. Commit occurs 3 clk cycles after the raw E falls.
- lcd_d_oe = synchronized E AND synchronized RW, registered (1-cycle output register).
- lcd_d_out, registered every cycle:
  - RS=0: {busy, AC}.
  - RS=1: DDRAM[AC].
- State machine:
  - IDLE: on a committed write, load the busy counter and go to BUSY; busy=1 from the cycle after commit.
  - BUSY: counter decrements each cycle; return to IDLE with busy=0 after exactly N cycles at 1, where N is CMD_CYCLES or CLEAR_CYCLES.
- Writes (RS=0) decoded by highest set bit:
  - 0x01 Clear: AC=0, I/D=1, N=CLEAR_CYCLES. DDRAM is not filled.
  - 0x02/0x03 Return Home: AC=0, N=CLEAR_CYCLES.
  - 0x04–0x07 Entry Mode: I/D=bit1; shift bit ignored.
  - 0x80|a: AC=a; a>=0x50 wraps to a-0x50.
  - All other codes are accepted with no effect, N=CMD_CYCLES.
- Data write (RS=1): DDRAM[AC]=data, then AC steps per I/D, N=CMD_CYCLES.
- AC wrap: increment from 0x4F gives 0x00; decrement from 0x00 gives 0x4F.
- Reads:
  - RS=0 read: returns {BF, AC}. Accepted at any time; no state change; no cmd_valid.
  - RS=1 read: data was presented while E was high; on commit, AC steps per I/D. Sets no busy; no cmd_valid.
- cmd_valid pulses in the commit cycle for accepted writes only.
- Any write or data read committed while busy=1 is ignored: no DDRAM, AC or counter change, and no cmd_valid.
- Reset mid-busy: immediate return to IDLE with busy=0.
- Commit coincident with the last busy cycle is treated as busy (ignored).

Optional Feature:
- Macro: LCD_RESP_VIOLATION_EN.
- Defined: protocol_err sets, and stays set until reset, on any ignored transaction (write or data read while busy). It also sets if RS, RW or D changes while synchronized E is high.
- Undefined: protocol_err is tied to 0 and the checks are not synthesized. Ignore-while-busy behaviour is unchanged.

Test Plan:
- Reset, then RS=0 read → lcd_d_oe=1, lcd_d_out=0x00 (BF=0, AC=0).
- Write instr 0x85, then wait out busy → busy high for exactly 1000 cycles; AC=0x05; cmd_valid pulse with cmd_rs=0, cmd_data=0x85.
- Write data 0x41 at AC=0x4F, I/D=1 → DDRAM[0x4F]=0x41, AC=0x00. Then set AC=0x4F and do an RS=1 read → 0x41, AC=0x00.
- Write 0x04 (decrement), set AC=0x00, write 0x5A → AC=0x4F; DDRAM[0x00]=0x5A.
- Write 0x01, then write 0x33 at cycle 500 after commit → write ignored, no cmd_valid, busy lasts 41000 cycles, AC=0. protocol_err=1 only with LCD_RESP_VIOLATION_EN.
- Assert reset 10 cycles into a CMD_CYCLES busy → busy=0, AC=0, protocol_err=0 immediately (asynchronous).
